dram_cmd_sequencer: RTL

Closed-page DDR4 command sequencer between the last-level cache memory port and the DIMM command/data pins. It accepts one 64-byte line read or write per request, then issues ACTIVATE, READ/WRITE and PRECHARGE with fixed latency spacing. It moves the 8-beat × 64-bit burst and returns the line or a write acknowledgement. It also schedules periodic REFRESH.

---
 rtl/dram_cmd_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_sequencer.sv
// rtl/dram_cmd_sequencer.sv - closed-page DDR4 command sequencer with periodic refresh
module dram_cmd_sequencer #(
    parameter int PADDR_BITS         = 19,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int CAS_LATENCY        = 22,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int REFRESH_CYCLE      = 5120,
    parameter int REFRESH_LATENCY    = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_we_in,
    input  logic [PADDR_BITS-1:0] req_addr_in,
    input  logic [511:0]          req_line_in,
    output logic                  resp_valid_out,
    input  logic                  resp_ready_in,
    output logic                  resp_we_out,
    output logic [511:0]          resp_line_out,
    output logic                  cs_N_out,
    output logic                  act_N_out,
    output logic [16:0]           addr_out,
    output logic [1:0]            bg_out,
    output logic [1:0]            ba_out,
    output logic [63:0]           dq_out,
    output logic                  dq_oe_out,
    input  logic [63:0]           dq_in
);

    localparam int CNT_W   = 16;
    localparam int REF_W   = $clog2(REFRESH_CYCLE + 1);
    localparam int COLHI_W = COL_BITS - 3;
    localparam int BG_LSB  = 6;
    localparam int BA_LSB  = 8;
    localparam int COL_LSB = 9;
    localparam int ROW_LSB = COL_LSB + COLHI_W;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_ACT_WAIT, S_CMD, S_CAS_WAIT, S_BURST,
        S_PRE, S_PRE_WAIT, S_RESP, S_REF, S_REF_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [REF_W-1:0]     r_ref_cnt;
    logic                 r_ref_pending;
    logic                 r_we;
    logic [ROW_BITS-1:0]  r_row;
    logic [1:0]           r_bg;
    logic                 r_ba0;
    logic [COLHI_W-1:0]   r_col_hi;
    logic [511:0]         r_line;
    logic                 w_accept;
    logic                 w_ref_wrap;
    logic                 w_unused_addr;

    assign w_accept      = (r_state == S_IDLE) && !r_ref_pending && req_valid_in;
    assign w_ref_wrap    = (r_ref_cnt == REF_W'(REFRESH_CYCLE - 1));
    assign w_unused_addr = ^{req_addr_in[BG_LSB-1:0], req_addr_in[PADDR_BITS-1:ROW_LSB+ROW_BITS]};
    assign resp_we_out   = r_we;
    assign resp_line_out = r_line;

    // state register
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // next-state logic; refresh wins over a new request in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (r_ref_pending) w_state_next = S_REF;
                        else if (req_valid_in) w_state_next = S_ACT;
            S_ACT:      w_state_next = S_ACT_WAIT;
            S_ACT_WAIT: if (r_cnt == CNT_W'(ACTIVATION_LATENCY - 1)) w_state_next = S_CMD;
            S_CMD:      w_state_next = S_CAS_WAIT;
            S_CAS_WAIT: if (r_cnt == CNT_W'(CAS_LATENCY - 2)) w_state_next = S_BURST;
            S_BURST:    if (r_cnt == CNT_W'(7)) w_state_next = S_PRE;
            S_PRE:      w_state_next = S_PRE_WAIT;
            S_PRE_WAIT: if (r_cnt == CNT_W'(PRECHARGE_LATENCY - 1)) w_state_next = S_RESP;
            S_RESP:     if (resp_ready_in) w_state_next = S_IDLE;
            S_REF:      w_state_next = S_REF_WAIT;
            S_REF_WAIT: if (r_cnt == CNT_W'(REFRESH_LATENCY - 1)) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // command pins, data bus and handshake outputs decoded from state
    always_comb begin
        cs_N_out       = 1'b1;
        act_N_out      = 1'b1;
        addr_out       = '0;
        bg_out         = '0;
        ba_out         = '0;
        dq_out         = '0;
        dq_oe_out      = 1'b0;
        resp_valid_out = 1'b0;
        req_ready_out  = 1'b0;
        case (r_state)
            S_IDLE: req_ready_out = !r_ref_pending;
            S_ACT: begin
                cs_N_out                = 1'b0;
                act_N_out               = 1'b0;
                addr_out[ROW_BITS-1:0]  = r_row;
                bg_out                  = r_bg;
                ba_out                  = {1'b0, r_ba0};
            end
            S_CMD: begin
                cs_N_out                = 1'b0;
                addr_out[16:14]         = r_we ? 3'b100 : 3'b101;
                addr_out[COL_BITS-1:0]  = {r_col_hi, 3'b000};
                bg_out                  = r_bg;
                ba_out                  = {1'b0, r_ba0};
            end
            S_BURST: begin
                dq_oe_out = r_we;
                dq_out    = r_we ? r_line[63:0] : 64'd0;
            end
            S_PRE: begin
                cs_N_out        = 1'b0;
                addr_out[16:14] = 3'b010;
                bg_out          = r_bg;
                ba_out          = {1'b0, r_ba0};
            end
            S_RESP: resp_valid_out = 1'b1;
            S_REF: begin
                cs_N_out        = 1'b0;
                addr_out[16:14] = 3'b001;
            end
            default: ;
        endcase
    end

    // per-state cycle counter, restarts whenever the state changes
    always_ff @(posedge clk_in) begin
        if (rst_in)                     r_cnt <= '0;
        else if (w_state_next != r_state) r_cnt <= '0;
        else                            r_cnt <= r_cnt + CNT_W'(1);
    end

    // free-running refresh interval counter; only one refresh is ever outstanding
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b0;
        end else begin
            r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + REF_W'(1);
            if (w_ref_wrap)            r_ref_pending <= 1'b1;
            else if (r_state == S_REF) r_ref_pending <= 1'b0;
        end
    end

    // request latch and line shifter: writes shift out beat 0 first and
    // back-fill zeros, reads shift dq_in in so beat k ends up at bits [64k+63:64k]
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_we     <= 1'b0;
            r_row    <= '0;
            r_bg     <= '0;
            r_ba0    <= 1'b0;
            r_col_hi <= '0;
            r_line   <= '0;
        end else if (w_accept) begin
            r_we     <= req_we_in;
            r_row    <= req_addr_in[ROW_LSB +: ROW_BITS];
            r_bg     <= req_addr_in[BG_LSB +: 2];
            r_ba0    <= req_addr_in[BA_LSB];
            r_col_hi <= req_addr_in[COL_LSB +: COLHI_W];
            r_line   <= req_line_in;
        end else if (r_state == S_BURST) begin
            r_line <= {(r_we ? 64'd0 : dq_in), r_line[511:64]};
        end
    end

endmodule
